// File: rtl/lane_car_counter_if.sv
// rtl/lane_car_counter_if.sv - sensor/green/strobe inputs and count/flag outputs of lane_car_counter
//
// Purpose: bundles the per-lane signals exchanged between the intersection
//          environment and lane_car_counter.
// Signals:
//    carSensor  [LANES]     per-lane car-presence level (arrival = 0->1)
//    laneOutput [LANES]     green-light vector, same lane order as carSensor
//    departTick             one-cycle strobe, each green lane discharges one car
//    clearOvf               synchronous clear of all overflow flags
//    carCounts  [LANES*CW]  registered per-lane counts, lane i at [CW*i +: CW]
//    overflow   [LANES]     sticky per-lane saturation flags
//    updated                one-cycle pulse after any count change
// Modports: master drives the inputs of the counter, slave is the counter.

interface lane_car_counter_if #(
   parameter int LANES = 8,
   parameter int CW    = 8
);
   logic [LANES-1:0]    carSensor;
   logic [LANES-1:0]    laneOutput;
   logic                departTick;
   logic                clearOvf;
   logic [LANES*CW-1:0] carCounts;
   logic [LANES-1:0]    overflow;
   logic                updated;

   modport master (
      output carSensor, laneOutput, departTick, clearOvf,
      input  carCounts, overflow, updated
   );

   modport slave (
      input  carSensor, laneOutput, departTick, clearOvf,
      output carCounts, overflow, updated
   );
endinterface

// File: rtl/lane_car_counter.sv
// rtl/lane_car_counter.sv - per-lane queued car counter with saturation and overflow flags
//
// Purpose: counts cars waiting in each lane. Arrivals come from asynchronous
//          presence sensors (synchronised, then edge-detected); departures
//          remove one car from every green lane on each departTick.
// Ports:
//    clk   rising-edge clock
//    rst   asynchronous active-high reset
//    bus   lane_car_counter_if.slave (sensor/green/strobe in, counts/flags out)
// Lane order of every vector: N1,N2,E1,E2,S1,S2,W1,W2 = bits 0..7.

module lane_car_counter #(
   parameter int LANES = 8,
   parameter int CW    = 8
) (
   input logic               clk,
   input logic               rst,
   lane_car_counter_if.slave bus
);

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   logic [LANES-1:0]    sync1_q, sync2_q, prev_q;
   logic [LANES*CW-1:0] counts_q, counts_d;
   logic [LANES-1:0]    ovf_q, ovf_d;
   logic                upd_q, upd_d;

   logic [LANES-1:0]    arrival;
   logic [LANES-1:0]    departure;
   logic [LANES-1:0]    ovf_set;

   always_comb begin
      counts_d  = counts_q;
      ovf_set   = '0;
      departure = '0;
      // sync2 vs prev gives exactly one arrival per rising sensor level,
      // so the count lands on the 3rd edge after the first high sample.
      arrival   = sync2_q & ~prev_q;

      for (int i = 0; i < LANES; i++) begin
         // An empty lane has nothing to discharge, so it never counts as a departure.
         departure[i] = bus.departTick & bus.laneOutput[i] &
                        (counts_q[CW*i +: CW] != '0);

         if (arrival[i] && !departure[i]) begin
            if (counts_q[CW*i +: CW] == CNT_MAX) begin
               ovf_set[i] = 1'b1;
            end else begin
               counts_d[CW*i +: CW] = counts_q[CW*i +: CW] + CNT_ONE;
            end
         end else if (departure[i] && !arrival[i]) begin
            counts_d[CW*i +: CW] = counts_q[CW*i +: CW] - CNT_ONE;
         end
      end

      // A flag being set on the clearing edge survives the clear.
      ovf_d = (bus.clearOvf ? '0 : ovf_q) | ovf_set;
      upd_d = (counts_d != counts_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         prev_q   <= '0;
         counts_q <= '0;
         ovf_q    <= '0;
         upd_q    <= 1'b0;
      end else begin
         sync1_q  <= bus.carSensor;
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         counts_q <= counts_d;
         ovf_q    <= ovf_d;
         upd_q    <= upd_d;
      end
   end

   assign bus.carCounts = counts_q;
   assign bus.overflow  = ovf_q;
   assign bus.updated   = upd_q;

endmodule

// File: tb/tb_lane_car_counter.sv
// tb/tb_lane_car_counter.sv - directed self-checking bench for lane_car_counter

module tb_lane_car_counter;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   lane_car_counter_if #(.LANES(8), .CW(8)) bus ();

   lane_car_counter #(.LANES(8), .CW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [7:0] lane_of(input int i);
      return bus.carCounts[8*i +: 8];
   endfunction

   // n one-cycle sensor pulses on every lane in mask, then drain the pipeline.
   task automatic arrive(input logic [7:0] mask, input int n);
      for (int k = 0; k < n; k++) begin
         bus.carSensor = mask;
         tick();
         bus.carSensor = 8'h00;
         tick();
      end
      tick(3);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst            = 1'b1;
      bus.carSensor  = 8'h00;
      bus.laneOutput = 8'h00;
      bus.departTick = 1'b0;
      bus.clearOvf   = 1'b0;
      tick(2);
      check_val("reset_counts",   bus.carCounts, 64'h0);
      check_val("reset_overflow", bus.overflow,  8'h00);
      check_val("reset_updated",  bus.updated,   1'b0);
      rst = 1'b0;

      // Single arrival on lane 0, sensor held 4 cycles.
      bus.carSensor = 8'h01;
      tick(2);
      check_val("lane0_after_edge2", lane_of(0), 8'd0);
      tick();
      check_val("lane0_after_edge3", lane_of(0), 8'd1);
      check_val("updated_after_edge3", bus.updated, 1'b1);
      tick();
      check_val("updated_after_edge4", bus.updated, 1'b0);
      bus.carSensor = 8'h00;
      tick(4);
      check_val("lane0_stable", lane_of(0), 8'd1);

      // Preload lane 2 = 8, lane 4 = 127, lane 7 = 255.
      arrive(8'b1001_0100, 8);
      arrive(8'b1001_0000, 119);
      arrive(8'b1000_0000, 128);
      check_val("preload_lane2", lane_of(2), 8'd8);
      check_val("preload_lane4", lane_of(4), 8'd127);
      check_val("preload_lane7", lane_of(7), 8'd255);
      check_val("preload_ovf",   bus.overflow, 8'h00);

      // Three departures on green lane 4.
      bus.laneOutput = 8'b0001_0000;
      bus.departTick = 1'b1;
      tick();
      check_val("lane4_first_depart", lane_of(4), 8'd126);
      tick(2);
      bus.departTick = 1'b0;
      check_val("lane4_after_3", lane_of(4), 8'd124);
      check_val("lane0_untouched", lane_of(0), 8'd1);
      check_val("lane2_untouched", lane_of(2), 8'd8);
      check_val("lane7_untouched", lane_of(7), 8'd255);

      // Red lanes never decrement; green lanes ignored without departTick.
      bus.laneOutput = 8'h00;
      bus.departTick = 1'b1;
      tick();
      bus.departTick = 1'b0;
      bus.laneOutput = 8'hFF;
      tick(2);
      bus.laneOutput = 8'h00;
      check_val("red_lane4_hold", lane_of(4), 8'd124);
      check_val("no_tick_lane2_hold", lane_of(2), 8'd8);
      check_val("no_change_updated", bus.updated, 1'b0);

      // Saturation on lane 7.
      arrive(8'h80, 1);
      check_val("sat_lane7", lane_of(7), 8'd255);
      check_val("sat_ovf", bus.overflow, 8'h80);
      bus.clearOvf = 1'b1;
      tick();
      bus.clearOvf = 1'b0;
      check_val("clear_ovf", bus.overflow, 8'h00);

      // Arrival coinciding with clearOvf: set wins.
      bus.carSensor = 8'h80;
      tick();
      bus.carSensor = 8'h00;
      tick();
      bus.clearOvf = 1'b1;
      tick();
      bus.clearOvf = 1'b0;
      check_val("set_wins_ovf", bus.overflow, 8'h80);
      bus.clearOvf = 1'b1;
      tick();
      bus.clearOvf = 1'b0;

      // Arrival and departure together at 255: no flag, stays 255.
      bus.carSensor = 8'h80;
      tick();
      bus.carSensor = 8'h00;
      tick();
      bus.laneOutput = 8'h80;
      bus.departTick = 1'b1;
      tick();
      bus.departTick = 1'b0;
      bus.laneOutput = 8'h00;
      check_val("both_at_max_lane7", lane_of(7), 8'd255);
      check_val("both_at_max_ovf", bus.overflow, 8'h00);

      // Lane 2 at 8: arrival and departure on the same edge.
      bus.carSensor = 8'h04;
      tick();
      bus.carSensor = 8'h00;
      tick();
      bus.laneOutput = 8'h04;
      bus.departTick = 1'b1;
      tick();
      bus.departTick = 1'b0;
      bus.laneOutput = 8'h00;
      check_val("both_lane2", lane_of(2), 8'd8);
      check_val("both_lane2_updated", bus.updated, 1'b0);

      // All zero with all green and departTick: nothing moves.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.laneOutput = 8'hFF;
      bus.departTick = 1'b1;
      tick();
      bus.departTick = 1'b0;
      check_val("zero_depart_counts", bus.carCounts, 64'h0);
      check_val("zero_depart_ovf", bus.overflow, 8'h00);
      tick();
      check_val("zero_depart_updated", bus.updated, 1'b0);
      bus.laneOutput = 8'h00;

      // Reset mid-count clears outputs before the next edge.
      arrive(8'h0F, 3);
      check_val("pre_rst_lane1", lane_of(1), 8'd3);
      bus.carSensor = 8'h0F;
      tick(3);
      check_val("pre_rst_updated", bus.updated, 1'b1);
      rst = 1'b1;
      #2;
      check_val("async_rst_counts", bus.carCounts, 64'h0);
      check_val("async_rst_ovf", bus.overflow, 8'h00);
      check_val("async_rst_updated", bus.updated, 1'b0);

      // Sensor held high across reset release: one arrival on the 3rd edge.
      bus.carSensor = 8'h20;
      tick();
      rst = 1'b0;
      tick(2);
      check_val("held_lane5_edge2", lane_of(5), 8'd0);
      tick();
      check_val("held_lane5_edge3", lane_of(5), 8'd1);
      tick(8);
      check_val("held_lane5_once", lane_of(5), 8'd1);
      bus.carSensor = 8'h00;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lane_car_counter.md
LANE_CAR_COUNTER -- requirements
Module: lane_car_counter

Interface
REQ-001 SHALL have parameter LANES, default 8, meaning number of lanes; lane bit order N1,N2,E1,E2,S1,S2,W1,W2 = bits 0..7.
REQ-002 SHALL have parameter CW, default 8, meaning per-lane count width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port carSensor  input  LANES  per-lane car-presence level; a car arrival is a 0->1 transition.
REQ-006 SHALL have port laneOutput  input  LANES  green-light vector from the DayTime controller, same bit order.
REQ-007 SHALL have port departTick  input  1  one-cycle strobe, synchronous to clk; each green lane discharges one car.
REQ-008 SHALL have port clearOvf  input  1  synchronous clear of all overflow flags.
REQ-009 SHALL have port carCounts  output  LANES*CW  registered per-lane counts; lane i occupies bits [CW*i+CW-1 : CW*i], matching DayTime's packed carCounts input.
REQ-010 SHALL have port overflow  output  LANES  sticky per-lane saturation flag.
REQ-011 SHALL have port updated  output  1  registered one-cycle pulse following any count change.

Function
REQ-012 SHALL pass each carSensor bit through a 2-flop synchronizer, then through a registered previous-value flop; arrival[i] = sync2[i] & ~prev[i].
REQ-013 SHALL apply an arrival to carCounts on the 3rd rising edge, counting the edge that first samples carSensor[i]=1 as the 1st; one arrival per 0->1 transition, regardless of high duration.
REQ-014 SHALL treat departure[i] = departTick & laneOutput[i] & (count[i] != 0), applied on the same edge departTick is sampled high (0 latency beyond the register).
REQ-015 SHALL compute per lane per edge: arrival only -> +1; departure only -> -1; both -> unchanged; neither -> unchanged.
REQ-016 SHALL saturate at 2^CW-1 (255): an arrival without departure at 255 leaves 255 and sets overflow[i].
REQ-017 SHALL NOT set overflow[i] when arrival and departure coincide at 255; the count stays 255.
REQ-018 SHALL leave a count of 0 at 0 on departTick with the lane green; no flag, no updated pulse.
REQ-019 SHALL ignore laneOutput bits while departTick=0; a red lane SHALL never decrement.
REQ-020 SHALL clear all overflow bits on an edge with clearOvf=1, except that a bit being set on that same edge SHALL end set (set wins).
REQ-021 SHALL assert updated for exactly the one cycle after any edge on which at least one carCounts lane changed value; otherwise updated=0.
REQ-022 SHALL update all lanes independently and simultaneously; no arbitration between lanes.

Reset
REQ-023 SHALL asynchronously clear carCounts, overflow, updated, synchronizer flops and prev flops to 0 while rst=1, including mid-operation.
REQ-024 SHALL, when carSensor[i] is held high across rst deassertion, count exactly one arrival for lane i, on the 3rd rising edge after deassertion.
REQ-025 SHALL ignore departTick, clearOvf and carSensor while rst=1.

Verification
REQ-026 Single pulse on carSensor[0] held 4 cycles -> carCounts[7:0] 0->1 on 3rd edge after first high sample, updated high 1 cycle, then stable.
REQ-027 Lane 4 preloaded to 127 via arrivals, laneOutput=8'b00010000, departTick high 3 cycles -> lane 4 = 124, other lanes unchanged.
REQ-028 Lane 7 at 255, one further arrival -> stays 255, overflow=8'b10000000; clearOvf pulse -> overflow=0; arrival coinciding with clearOvf -> overflow[7] remains 1.
REQ-029 Lane 2 at 8, arrival and departTick (lane 2 green) on same edge -> stays 8, updated stays 0.
REQ-030 laneOutput=8'hFF, departTick with all counts 0 -> all remain 0, no updated pulse; then rst asserted mid-count with counts nonzero -> all outputs 0 immediately, before the next clk edge.
